imem_boot_loader: RTL and testbench

//  Upstream feeder of the single-cycle mips core. Streams 32-bit instruction words over valid/ready

---
 rtl/imem_boot_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Purpose:
//   Upstream feeder for the single-cycle MIPS core. It accepts a program as a
//   stream of 32-bit instruction words over a valid/ready handshake and writes
//   each word into instruction memory at consecutive word addresses. The core
//   is held in reset while the load is in progress. When the last word has
//   been written, the core is released for exactly RUN_CYCLES clock-enabled
//   cycles and then frozen, with done raised. If DEPTH words arrive without
//   in_last, the loader stops in a sticky overflow state and never releases
//   the core.
//
// Parameters:
//   ADDR_W      imem word-address width
//   DEPTH       words accepted before overflow (DEPTH <= 2**ADDR_W)
//   RUN_CYCLES  clock-enabled core cycles after release (>= 1)
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   in_valid       in   instruction word offered
//   in_ready       out  loader accepts a word this cycle
//   in_data        in   instruction word
//   in_last        in   qualifies the final word of the program
//   imem_we        out  imem write strobe
//   imem_addr      out  imem word address
//   imem_wdata     out  imem write data
//   core_reset     out  synchronous active-high reset to the core
//   core_clk_en    out  clock enable to the core
//   words_loaded   out  number of accepted words
//   done           out  run budget exhausted
//   overflow_err   out  sticky: DEPTH words accepted without in_last
//   checksum       out  (BOOT_CHECKSUM_EN only) wrap-around sum of accepted words
//
// Build options:
//   BOOT_CHECKSUM_EN  when defined, adds the checksum output and its adder.
//
// All outputs are registered. Outputs that depend only on the phase of the
// sequence (core_reset, core_clk_en, done) are registered from the current
// state, so they trail the state register by one cycle. This is what gives
// the release timing: last accept at edge t, final imem write visible after
// t, core released after t+2, done after t+2+RUN_CYCLES.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RUN_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              core_clk_en,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
`ifdef BOOT_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              overflow_err
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_HALT
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_reset_q;
    logic                core_clk_en_q;
    logic [ADDR_W:0]     words_loaded_q;
    logic                done_q;
    logic                overflow_err_q;
    logic [CNT_W-1:0]    run_cnt_q;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]         checksum_q;
`endif

    // A handshake completes only while loading; in_ready_q is already low in
    // every other state, the state term just makes that explicit.
    logic accept;
    assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_LOAD;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_reset_q   <= 1'b1;
            core_clk_en_q  <= 1'b0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            overflow_err_q <= 1'b0;
            run_cnt_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse following each accept.
            imem_we_q <= 1'b0;

            unique case (state_q)
                S_LOAD: begin
                    in_ready_q    <= 1'b1;
                    core_reset_q  <= 1'b1;
                    core_clk_en_q <= 1'b0;
                    if (accept) begin
                        imem_we_q      <= 1'b1;
                        imem_addr_q    <= words_loaded_q[ADDR_W-1:0];
                        imem_wdata_q   <= in_data;
                        words_loaded_q <= words_loaded_q + (ADDR_W + 1)'(1);
`ifdef BOOT_CHECKSUM_EN
                        checksum_q     <= checksum_q + in_data;
`endif
                        // in_ready must drop on the accepting edge so no
                        // further word slips in; in_last takes precedence
                        // over the overflow check on the final slot.
                        if (in_last) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_RELEASE;
                        end else if (words_loaded_q == LAST_SLOT) begin
                            in_ready_q     <= 1'b0;
                            overflow_err_q <= 1'b1;
                            state_q        <= S_HALT;
                        end
                    end
                end

                S_RELEASE: begin
                    // One cycle for the final write to land before release.
                    in_ready_q    <= 1'b0;
                    core_reset_q  <= 1'b1;
                    core_clk_en_q <= 1'b0;
                    run_cnt_q     <= '0;
                    state_q       <= S_RUN;
                end

                S_RUN: begin
                    in_ready_q    <= 1'b0;
                    core_reset_q  <= 1'b0;
                    core_clk_en_q <= 1'b1;
                    if (run_cnt_q == RUN_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Core stays out of reset so its state can be inspected.
                    in_ready_q    <= 1'b0;
                    core_reset_q  <= 1'b0;
                    core_clk_en_q <= 1'b0;
                    done_q        <= 1'b1;
                end

                S_HALT: begin
                    in_ready_q     <= 1'b0;
                    core_reset_q   <= 1'b1;
                    core_clk_en_q  <= 1'b0;
                    overflow_err_q <= 1'b1;
                end

                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign core_clk_en  = core_clk_en_q;
    assign words_loaded = words_loaded_q;
    assign done         = done_q;
    assign overflow_err = overflow_err_q;
`ifdef BOOT_CHECKSUM_EN
    assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Bench for imem_boot_loader with ADDR_W=3, DEPTH=4, RUN_CYCLES=4.
// The reference model tracks the load at transaction level: number of words
// accepted, the edge index of the last accept and an overflow flag. The core
// control outputs are derived from the edge index alone using the release
// timeline (released two edges after the last accept, done RUN_CYCLES edges
// after that).
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int RUNC   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              core_clk_en;
    logic [ADDR_W:0]   words_loaded;
    logic              done;
    logic              overflow_err;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RUN_CYCLES(RUNC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_reset  (core_reset),
        .core_clk_en (core_clk_en),
        .words_loaded(words_loaded),
        .done        (done),
`ifdef BOOT_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_rdy;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_wdata;
    int          m_loaded;
    int          m_tlast;
    bit          m_ovf;
    int          m_k;
    logic [31:0] m_cs;

    typedef struct {
        bit          rst;
        bit          vld;
        bit          last;
        logic [31:0] data;
        bit          rdy;
        bit          we;
        int          addr;
        logic [31:0] wdata;
        bit          crst;
        bit          cen;
        bit          dn;
        int          wl;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, want 0x%0h (edge %0d after reset)", tag, nm, act, exp, m_k);
        end
    endtask

    // Apply one cycle of inputs, clock once, then advance the model.
    task automatic step(input bit r, input bit v, input bit l, input logic [31:0] d);
        bit acc;
        reset = r; in_valid = v; in_last = l; in_data = d;
        @(posedge clock);
        #1;
        if (r) begin
            m_rdy = 0; m_we = 0; m_addr = 0; m_wdata = '0; m_loaded = 0;
            m_tlast = -1; m_ovf = 0; m_k = 0; m_cs = '0;
        end else begin
            m_k++;
            acc = v && m_rdy;
            m_we = acc;
            if (acc) begin
                m_addr = m_loaded;
                m_wdata = d;
                m_loaded++;
                m_cs = m_cs + d;
                if (l) m_tlast = m_k;
                else if (m_loaded == DEPTH) m_ovf = 1;
            end
            m_rdy = (m_tlast < 0) && !m_ovf;
        end
    endtask

    task automatic check_model(input string tag);
        bit e_crst, e_cen, e_done;
        e_crst = (m_tlast < 0) || (m_k < m_tlast + 2);
        e_cen  = (m_tlast >= 0) && (m_k >= m_tlast + 2) && (m_k < m_tlast + 2 + RUNC);
        e_done = (m_tlast >= 0) && (m_k >= m_tlast + 2 + RUNC);
        chk(tag, "in_ready", in_ready, m_rdy);
        chk(tag, "imem_we", imem_we, m_we);
        if (m_we) begin
            chk(tag, "imem_addr", imem_addr, m_addr);
            chk(tag, "imem_wdata", imem_wdata, m_wdata);
        end
        chk(tag, "core_reset", core_reset, e_crst);
        chk(tag, "core_clk_en", core_clk_en, e_cen);
        chk(tag, "done", done, e_done);
        chk(tag, "words_loaded", words_loaded, m_loaded);
        chk(tag, "overflow_err", overflow_err, m_ovf);
`ifdef BOOT_CHECKSUM_EN
        chk(tag, "checksum", checksum, m_cs);
`endif
    endtask

    task automatic run(input string tag, input bit r, input bit v, input bit l, input logic [31:0] d);
        step(r, v, l, d);
        check_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w [3];
        int idx;
        int plen;
        bit v, l, r;
        bit pat [6];

        w[0] = 32'h20010005; w[1] = 32'h20020003; w[2] = 32'h00221820;

        //            rst vld lst data  | rdy we adr wdata | crst cen dn wl
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, w[0],  1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, w[0],  1'b1, 1'b1, 0, w[0],  1'b1, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, w[1],  1'b1, 1'b1, 1, w[1],  1'b1, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, w[2],  1'b0, 1'b1, 2, w[2],  1'b1, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, 3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, 3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, 3};

        // Directed table: three-word program, no gaps, then the run budget.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].last, tbl[i].data);
            chk("tbl", "in_ready", in_ready, tbl[i].rdy);
            chk("tbl", "imem_we", imem_we, tbl[i].we);
            if (tbl[i].we) begin
                chk("tbl", "imem_addr", imem_addr, tbl[i].addr);
                chk("tbl", "imem_wdata", imem_wdata, tbl[i].wdata);
            end
            chk("tbl", "core_reset", core_reset, tbl[i].crst);
            chk("tbl", "core_clk_en", core_clk_en, tbl[i].cen);
            chk("tbl", "done", done, tbl[i].dn);
            chk("tbl", "words_loaded", words_loaded, tbl[i].wl);
            chk("tbl", "overflow_err", overflow_err, 1'b0);
        end

        // Gapped valid pattern: writes only on accepts, addresses contiguous.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run("gap", 1, 0, 0, 0);
        run("gap", 0, 0, 0, 0);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            v = pat[i];
            run("gap", 0, v, v && (idx == 2), v ? w[idx] : $urandom);
            if (m_we) idx++;
        end
        for (int i = 0; i < 8; i++) run("gap", 0, 0, 0, 0);
        chk("gap", "done_end", done, 1'b1);
        chk("gap", "words_end", words_loaded, 3);

        // Overflow: DEPTH words without in_last, then valid keeps offering.
        run("ovf", 1, 0, 0, 0);
        run("ovf", 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) run("ovf", 0, 1, 0, $urandom);
        for (int i = 0; i < 6; i++) run("ovf", 0, 1, 0, $urandom);
        chk("ovf", "overflow_end", overflow_err, 1'b1);
        chk("ovf", "ready_end", in_ready, 1'b0);
        chk("ovf", "core_reset_end", core_reset, 1'b1);
        chk("ovf", "done_end", done, 1'b0);

        // Reset in the second run cycle, then reload a single word.
        run("rst", 1, 0, 0, 0);
        run("rst", 0, 0, 0, 0);
        run("rst", 0, 1, 1, 32'h1234_5678);
        run("rst", 0, 0, 0, 0);
        run("rst", 0, 0, 0, 0);
        chk("rst", "clk_en_run1", core_clk_en, 1'b1);
        run("rst", 0, 0, 0, 0);
        run("rst", 1, 0, 0, 0);
        chk("rst", "core_reset_abort", core_reset, 1'b1);
        chk("rst", "clk_en_abort", core_clk_en, 1'b0);
        chk("rst", "words_abort", words_loaded, 0);
        run("rst", 0, 0, 0, 0);
        chk("rst", "ready_again", in_ready, 1'b1);
        run("rst", 0, 1, 1, 32'hCAFE_F00D);
        for (int i = 0; i < RUNC + 3; i++) run("rst", 0, 0, 0, 0);
        chk("rst", "done_reload", done, 1'b1);

        // Valid held through RUN/DONE; in_last alone is ignored while loading.
        run("hold", 1, 0, 0, 0);
        run("hold", 0, 0, 1, 0);
        run("hold", 0, 0, 1, 0);
        run("hold", 0, 1, 0, 32'h1111_1111);
        run("hold", 0, 1, 1, 32'h2222_2222);
        for (int i = 0; i < 10; i++) run("hold", 0, 1, 1'($urandom), $urandom);
        chk("hold", "words_end", words_loaded, 2);

        // Checksum wrap-around.
        run("csum", 1, 0, 0, 0);
        run("csum", 0, 0, 0, 0);
        run("csum", 0, 1, 0, 32'hFFFF_FFFF);
        run("csum", 0, 1, 1, 32'h0000_0002);
        run("csum", 0, 0, 0, 0);
`ifdef BOOT_CHECKSUM_EN
        chk("csum", "checksum_wrap", checksum, 32'h0000_0001);
`endif
        chk("csum", "words_end", words_loaded, 2);

        // Randomized programs, gaps, occasional overflow and stray resets.
        for (int s = 0; s < 25; s++) begin
            run("rand", 1, 0, 0, 0);
            plen = $urandom_range(1, DEPTH + 1);
            for (int c = 0; c < 30; c++) begin
                r = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 3) != 0);
                l = v ? (m_loaded == plen - 1) : 1'($urandom);
                run("rand", r, v, l, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
